td4_core_p: RTL and testbench
=============================

TD4_CORE_P -- requirements
Module: td4_core_p

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set register, immediate, port and PC width; program depth SHALL be 2**DATA_W words.
REQ-002 Parameter IW, fixed as 4+DATA_W, SHALL be the instruction width: opcode [IW-1:DATA_W], immediate [DATA_W-1:0].
REQ-003 Port clock  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port run  in  1  1 = execute one instruction every cycle; 0 = single-step mode.
REQ-006 Port step  in  1  single-step request; its rising edge SHALL be detected in the core.
REQ-007 Port sw  in  DATA_W  input port read by IN instructions.
REQ-008 Port prog_we  in  1  program-memory write strobe.
REQ-009 Port prog_addr  in  DATA_W  program-memory write address.
REQ-010 Port prog_data  in  IW  program-memory write data.
REQ-011 Port LED  out  DATA_W  output-port register.
REQ-012 Port debug  out  DATA_W  current PC.
REQ-013 Port halted  out  1  high once HLT has executed.

Function
REQ-014 State SHALL be: A, B, OUT, PC (all DATA_W), carry flag C, halted flag H, step_q (previous step sample), program RAM of 2**DATA_W x IW.
REQ-015 exec SHALL be high when !H && !prog_we && (run || (step && !step_q)); step_q SHALL update every cycle.
REQ-016 On an exec cycle exactly one instruction, mem[PC], SHALL complete; on non-exec cycles A, B, OUT, PC and C SHALL hold.
REQ-017 Opcodes: 0000 A=A+Im; 0001 A=B; 0010 A=sw; 0011 A=Im; 0100 B=A; 0101 B=B+Im; 0110 B=sw; 0111 B=Im; 1001 OUT=B; 1011 OUT=Im; 1110 JNC Im; 1111 JMP Im; 1101 HLT; 1000, 1010, 1100 NOP.
REQ-018 Adds SHALL be DATA_W-bit, modulo 2**DATA_W; the carry-out SHALL load C.
REQ-019 Every non-add instruction, including NOP, jumps and HLT, SHALL clear C.
REQ-020 JNC SHALL load PC=Im when C is 0 before the instruction, else PC=PC+1.
REQ-021 JMP SHALL load PC=Im unconditionally.
REQ-022 All other instructions SHALL set PC=PC+1, wrapping from 2**DATA_W-1 to 0.
REQ-023 HLT SHALL set H, leave PC on the HLT address, and block execution until reset; run and step SHALL be ignored while H=1.
REQ-024 sw SHALL be sampled on the exec edge, with no input synchroniser.
REQ-025 LED SHALL be driven directly from OUT; debug SHALL be driven directly from PC; halted SHALL be driven directly from H.
REQ-026 prog_we=1 SHALL write prog_data to mem[prog_addr] at the clock edge.
REQ-027 A write to mem[PC] SHALL be seen by the next exec.
REQ-028 A prog_we cycle that coincides with a step edge SHALL drop that step; software SHALL re-pulse step.

Reset
REQ-029 reset=0 SHALL asynchronously clear A, B, OUT, PC, C, H and step_q, so LED=0, debug=0 and halted=0.
REQ-030 Program RAM SHALL NOT be cleared by reset, so a loaded program survives reset.
REQ-031 Reset asserted mid-run SHALL abort the in-flight instruction with no partial state update.
REQ-032 After reset release, the first exec SHALL fetch mem[0].

Verification (DATA_W=4)
REQ-033 Load {0011_0111 A=7, 0000_1010 A+=10, 1110_0101 JNC 5}, run=1 -> A=1 and C=1 after cycle 2; JNC not taken, PC=3.
REQ-034 Load {0111_0011 B=3, 1001_0000 OUT=B, 1101_0000 HLT}, run=1 -> LED=3 from cycle 2; halted=1 with debug=2 and held for 10+ cycles; reset -> LED=0, halted=0, debug=0.
REQ-035 Run=0, step held high for 5 cycles -> exactly one instruction executes and debug goes 0->1; a second pulse -> debug=2.
REQ-036 mem[15]=1011_0101 OUT 5, mem[0]=1011_1001 OUT 9, PC at 15 -> LED=5, then debug wraps to 0, then LED=9.
REQ-037 Drop reset mid-run with A=0xC -> A=0 and debug=0 in the same cycle; program RAM intact, and the rerun reproduces the original sequence.
REQ-038 sw=0xA, run=1, mem[0]=0010_0000 IN A, mem[1]=0000_0111 A+=7 -> A=0xA, then A=1 with C=1.

Source files
------------

// File: rtl/td4_core_p_if.sv
// Control, program-load and output-port signals of the TD4 core.
// The bench drives through master; the core sits on slave.
interface td4_core_p_if #(
    parameter int DATA_W = 4
);
    localparam int IW = 4 + DATA_W;

    logic              run;
    logic              step;
    logic [DATA_W-1:0] sw;
    logic              prog_we;
    logic [DATA_W-1:0] prog_addr;
    logic [IW-1:0]     prog_data;
    logic [DATA_W-1:0] LED;
    logic [DATA_W-1:0] debug;
    logic              halted;

    modport master (
        output run, step, sw, prog_we, prog_addr, prog_data,
        input  LED, debug, halted
    );

    modport slave (
        input  run, step, sw, prog_we, prog_addr, prog_data,
        output LED, debug, halted
    );
endinterface

// File: rtl/td4_core_p.sv
// TD4-style 4-bit CPU: one instruction per exec cycle (free-run or stepped).
// Program RAM writes take priority and suppress execution for that cycle.
module td4_core_p #(
    parameter int DATA_W = 4
) (
    input  logic        clock,
    input  logic        reset,
    td4_core_p_if.slave bus
);
    localparam int IW    = 4 + DATA_W;
    localparam int DEPTH = 2 ** DATA_W;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_A  = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_B  = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_I  = 4'b1011,
        OP_HLT    = 4'b1101,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } op_e;

    logic [IW-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d, pc_q, pc_d;
    logic              c_q, c_d, h_q, h_d, step_q;

    logic              exec;
    logic [IW-1:0]     instr;
    op_e               op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W:0]   sum_a, sum_b;

    assign exec  = !h_q && !bus.prog_we && (bus.run || (bus.step && !step_q));
    assign instr = mem_q[pc_q];
    assign op    = op_e'(instr[IW-1:DATA_W]);
    assign imm   = instr[DATA_W-1:0];
    assign sum_a = {1'b0, a_q} + {1'b0, imm};
    assign sum_b = {1'b0, b_q} + {1'b0, imm};

    // RAM is deliberately outside the reset domain so a loaded program survives reset.
    always_ff @(posedge clock) begin
        if (bus.prog_we) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        pc_d  = pc_q;
        c_d   = c_q;
        h_d   = h_q;
        if (exec) begin
            c_d  = 1'b0;
            pc_d = pc_q + DATA_W'(1);
            case (op)
                OP_ADD_A:  {c_d, a_d} = sum_a;
                OP_MOV_AB: a_d = b_q;
                OP_IN_A:   a_d = bus.sw;
                OP_MOV_A:  a_d = imm;
                OP_MOV_BA: b_d = a_q;
                OP_ADD_B:  {c_d, b_d} = sum_b;
                OP_IN_B:   b_d = bus.sw;
                OP_MOV_B:  b_d = imm;
                OP_OUT_B:  out_d = b_q;
                OP_OUT_I:  out_d = imm;
                OP_JNC:    if (!c_q) pc_d = imm;
                OP_JMP:    pc_d = imm;
                OP_HLT: begin
                    h_d  = 1'b1;
                    pc_d = pc_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            out_q  <= '0;
            pc_q   <= '0;
            c_q    <= 1'b0;
            h_q    <= 1'b0;
            step_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            out_q  <= out_d;
            pc_q   <= pc_d;
            c_q    <= c_d;
            h_q    <= h_d;
            step_q <= bus.step;
        end
    end

    assign bus.LED    = out_q;
    assign bus.debug  = pc_q;
    assign bus.halted = h_q;
endmodule

// File: tb/tb_td4_core_p.sv
// Randomised and directed stimulus for td4_core_p against an arithmetic reference model.
module tb_td4_core_p;
    localparam int DW = 4;
    localparam int N  = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    td4_core_p_if #(.DATA_W(DW)) bus ();
    td4_core_p #(.DATA_W(DW)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        int    led;
        int    pc;
        int    h;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string tag     = "init";

    int mA, mB, mO, mPC, mC, mH, mSq;
    int mem[N];

    function automatic void chk(string name, logic [8:0] got, logic [8:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got LED=%h debug=%h halted=%b, expected LED=%h debug=%h halted=%b",
                     name, got[8:5], got[4:1], got[0], want[8:5], want[4:1], want[0]);
        end
    endfunction

    function automatic void model_reset();
        mA = 0; mB = 0; mO = 0; mPC = 0; mC = 0; mH = 0; mSq = 0;
    endfunction

    function automatic void model_cycle(int run, int step, int sw, int we, int addr, int data);
        int ins, op, im, npc, s, cin;
        if (mH == 0 && we == 0 && (run != 0 || (step != 0 && mSq == 0))) begin
            ins = mem[mPC];
            op  = ins / N;
            im  = ins % N;
            cin = mC;
            mC  = 0;
            npc = (mPC + 1) % N;
            case (op)
                0:  begin s = mA + im; mA = s % N; mC = s / N; end
                1:  mA = mB;
                2:  mA = sw;
                3:  mA = im;
                4:  mB = mA;
                5:  begin s = mB + im; mB = s % N; mC = s / N; end
                6:  mB = sw;
                7:  mB = im;
                9:  mO = mB;
                11: mO = im;
                13: begin mH = 1; npc = mPC; end
                14: if (cin == 0) npc = im;
                15: npc = im;
                default: ;
            endcase
            mPC = npc;
        end
        if (we != 0) mem[addr] = data;
        mSq = step;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.led = mO; e.pc = mPC; e.h = mH; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    task automatic cyc(input int run, input int step, input int sw,
                       input int we = 0, input int addr = 0, input int data = 0);
        @(negedge clock);
        bus.run       = run[0];
        bus.step      = step[0];
        bus.sw        = 4'(sw);
        bus.prog_we   = we[0];
        bus.prog_addr = 4'(addr);
        bus.prog_data = 8'(data);
        model_cycle(run, step, sw, we, addr, data);
        push_exp();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b0;
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.prog_we   = 1'b0;
        model_reset();
        #2;
        chk({tag, "_async_rst"}, {bus.LED, bus.debug, bus.halted}, 9'd0);
        push_exp();
        @(negedge clock);
        reset = 1'b1;
        model_cycle(0, 0, 0, 0, 0, 0);
        push_exp();
    endtask

    task automatic load_prog(input int p[$]);
        for (int i = 0; i < N; i++)
            cyc(0, 0, 0, 1, i, (i < p.size()) ? p[i] : 8'hD0);
    endtask

    task automatic run_n(input int n, input int sw = 0);
        repeat (n) cyc(1, 0, sw);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, {bus.LED, bus.debug, bus.halted},
                {4'(e.led), 4'(e.pc), 1'(e.h)});
        end
    end

    initial begin
        int p[$];
        foreach (mem[i]) mem[i] = 0;
        bus.run = 1'b0; bus.step = 1'b0; bus.sw = '0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        tag = "reset";
        model_reset();
        do_reset();

        // Carry from A=7+10, JNC falls through, then expose A on LED.
        tag = "add_carry_jnc";
        p = '{8'h37, 8'h0A, 8'hE5, 8'h40, 8'h90, 8'hD0};
        load_prog(p);
        do_reset();
        run_n(8);

        tag = "out_b_halt";
        p = '{8'h73, 8'h90, 8'hD0};
        load_prog(p);
        do_reset();
        run_n(15);
        repeat (3) cyc(0, 1, 0);
        do_reset();

        // Step held high for 5 cycles executes once; prog_we on a step edge drops it.
        tag = "single_step";
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        load_prog(p);
        do_reset();
        repeat (5) cyc(0, 1, 0);
        repeat (2) cyc(0, 0, 0);
        repeat (3) cyc(0, 1, 0);
        cyc(0, 0, 0);
        tag = "step_vs_we";
        cyc(0, 1, 0, 1, 12, 8'hB7);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);

        tag = "pc_wrap";
        p = '{8'hB9, 8'hFF};
        load_prog(p);
        cyc(0, 0, 0, 1, 15, 8'hB5);
        do_reset();
        run_n(6);

        tag = "reset_midrun";
        p = '{8'h03, 8'h40, 8'h90, 8'hF0};
        load_prog(p);
        do_reset();
        run_n(14);
        do_reset();
        run_n(14);

        tag = "in_add";
        p = '{8'h20, 8'h07, 8'hE7, 8'h40, 8'h90, 8'h10, 8'h5F, 8'h49, 8'h90, 8'hD0};
        load_prog(p);
        do_reset();
        run_n(12, 4'hA);

        tag = "write_at_pc";
        p = '{8'hB1, 8'h80, 8'hF1};
        load_prog(p);
        do_reset();
        run_n(3);
        cyc(0, 0, 0, 1, mPC, 8'hB6);
        run_n(3);

        tag = "random";
        for (int seg = 0; seg < 12; seg++) begin
            for (int i = 0; i < N; i++) begin
                int w;
                w = $urandom_range(0, 255);
                if (w / N == 13 && $urandom_range(0, 3) != 0) w = 8'h80 | (w % N);
                cyc(0, 0, 0, 1, i, w);
            end
            do_reset();
            for (int k = 0; k < 80; k++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 2) do_reset();
                else cyc(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
                         $urandom_range(0, 15), (r < 8) ? 1 : 0,
                         $urandom_range(0, 15), $urandom_range(0, 255));
            end
        end

        repeat (3) @(negedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
